// File: rtl/riscv_core_muxnx1_pipe.sv
// riscv_core_muxnx1_pipe
//   N-input operand/forwarding selector with an optional output register.
//   Select is binary (SEL_MODE=0) or one-hot with lowest-index priority
//   (SEL_MODE=1). Illegal selects produce zero data, raise o_mux_sel_err,
//   and bump a saturating debug counter when the entry is accepted.
// Ports:
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_mux_in            NUM_IN flattened XLEN inputs, input k at [k*XLEN +: XLEN]
//   i_mux_sel           select, binary or one-hot
//   i_mux_valid         input valid
//   i_mux_stall         hold the output register (REG_OUT=1 only)
//   i_mux_flush         kill the registered/presented entry
//   o_mux_out           selected data
//   o_mux_valid         output valid
//   o_mux_sel_err       illegal select for the presented/held entry
//   o_mux_err_cnt       saturating count of accepted illegal selects
module riscv_core_muxnx1_pipe #(
    parameter int  XLEN      = 64,
    parameter int  NUM_IN    = 4,
    parameter int  SEL_MODE  = 0,
    parameter int  REG_OUT   = 1,
    parameter int  ERR_CNT_W = 8,
    localparam int SEL_W     = (SEL_MODE != 0) ? NUM_IN : $clog2(NUM_IN)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_IN*XLEN-1:0] i_mux_in,
    input  logic [SEL_W-1:0]       i_mux_sel,
    input  logic                   i_mux_valid,
    input  logic                   i_mux_stall,
    input  logic                   i_mux_flush,
    output logic [XLEN-1:0]        o_mux_out,
    output logic                   o_mux_valid,
    output logic                   o_mux_sel_err,
    output logic [ERR_CNT_W-1:0]   o_mux_err_cnt
);

    if ((NUM_IN < 2) || (NUM_IN > 16)) begin : g_bad_num_in
        $error("riscv_core_muxnx1_pipe: NUM_IN must be in 2..16");
    end

    logic [NUM_IN-1:0][XLEN-1:0] ins;
    logic [XLEN-1:0]             result;
    logic                        err;

    assign ins = i_mux_in;

    // ---------------- select decode ----------------
    if (SEL_MODE == 0) begin : g_bin
        // For power-of-two NUM_IN every code matches some k, so err folds to 0.
        always_comb begin
            result = '0;
            err    = 1'b1;
            for (int k = 0; k < NUM_IN; k++) begin
                if (i_mux_sel == SEL_W'(k)) begin
                    result = ins[k];
                    err    = 1'b0;
                end
            end
        end
    end else begin : g_onehot
        // Scan high to low so the lowest set bit is the last writer and wins.
        always_comb begin
            result = '0;
            err    = 1'b1;
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                if (i_mux_sel[k]) begin
                    result = ins[k];
                    err    = 1'b0;
                end
            end
        end
    end

    // ---------------- error counter ----------------
    // Stall only gates acceptance when there is a register to hold.
    logic accept;
    logic [ERR_CNT_W-1:0] err_cnt;

    assign accept = i_mux_valid & ~i_mux_flush &
                    ((REG_OUT != 0) ? ~i_mux_stall : 1'b1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_cnt <= '0;
        end else if (accept && err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign o_mux_err_cnt = err_cnt;

    // ---------------- output stage ----------------
    if (REG_OUT != 0) begin : g_reg
        logic [XLEN-1:0] out_q;
        logic            vld_pipe;
        logic            err_q;

        // Flush beats stall beats new input. Data is never cleared except
        // by reset; only valid/err are killed.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                out_q    <= '0;
                vld_pipe <= 1'b0;
                err_q    <= 1'b0;
            end else if (i_mux_flush) begin
                vld_pipe <= 1'b0;
                err_q    <= 1'b0;
            end else if (!i_mux_stall) begin
                vld_pipe <= i_mux_valid;
                if (i_mux_valid) begin
                    out_q <= result;
                    err_q <= err;
                end else begin
                    err_q <= 1'b0;
                end
            end
        end

        assign o_mux_out     = out_q;
        assign o_mux_valid   = vld_pipe;
        assign o_mux_sel_err = err_q;
    end else begin : g_comb
        assign o_mux_out     = result;
        assign o_mux_valid   = i_mux_valid & ~i_mux_flush;
        assign o_mux_sel_err = err & o_mux_valid;
    end

endmodule

// File: tb/tb_riscv_core_muxnx1_pipe.sv
// Testbench for riscv_core_muxnx1_pipe. Three instances:
//   A: NUM_IN=3, binary, registered
//   B: NUM_IN=4, one-hot, registered
//   C: NUM_IN=3, binary, combinational
// A reference model kept here tracks expected outputs per clock edge.
module tb_riscv_core_muxnx1_pipe;
    localparam int XL = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // instance A
    logic [3*XL-1:0] a_in;
    logic [1:0]      a_sel;
    logic            a_valid, a_stall, a_flush;
    logic [XL-1:0]   a_out;
    logic            a_vld, a_err;
    logic [7:0]      a_cnt;
    // instance B
    logic [4*XL-1:0] b_in;
    logic [3:0]      b_sel;
    logic            b_valid, b_stall, b_flush;
    logic [XL-1:0]   b_out;
    logic            b_vld, b_err;
    logic [7:0]      b_cnt;
    // instance C
    logic [3*XL-1:0] c_in;
    logic [1:0]      c_sel;
    logic            c_valid, c_stall, c_flush;
    logic [XL-1:0]   c_out;
    logic            c_vld, c_err;
    logic [7:0]      c_cnt;

    riscv_core_muxnx1_pipe #(.XLEN(XL), .NUM_IN(3), .SEL_MODE(0), .REG_OUT(1), .ERR_CNT_W(8)) u_a (
        .i_clk(clk), .i_rst(rst), .i_mux_in(a_in), .i_mux_sel(a_sel),
        .i_mux_valid(a_valid), .i_mux_stall(a_stall), .i_mux_flush(a_flush),
        .o_mux_out(a_out), .o_mux_valid(a_vld), .o_mux_sel_err(a_err), .o_mux_err_cnt(a_cnt));

    riscv_core_muxnx1_pipe #(.XLEN(XL), .NUM_IN(4), .SEL_MODE(1), .REG_OUT(1), .ERR_CNT_W(8)) u_b (
        .i_clk(clk), .i_rst(rst), .i_mux_in(b_in), .i_mux_sel(b_sel),
        .i_mux_valid(b_valid), .i_mux_stall(b_stall), .i_mux_flush(b_flush),
        .o_mux_out(b_out), .o_mux_valid(b_vld), .o_mux_sel_err(b_err), .o_mux_err_cnt(b_cnt));

    riscv_core_muxnx1_pipe #(.XLEN(XL), .NUM_IN(3), .SEL_MODE(0), .REG_OUT(0), .ERR_CNT_W(8)) u_c (
        .i_clk(clk), .i_rst(rst), .i_mux_in(c_in), .i_mux_sel(c_sel),
        .i_mux_valid(c_valid), .i_mux_stall(c_stall), .i_mux_flush(c_flush),
        .o_mux_out(c_out), .o_mux_valid(c_vld), .o_mux_sel_err(c_err), .o_mux_err_cnt(c_cnt));

    // reference model state
    logic [XL-1:0] ma_out, mb_out;
    logic          ma_vld, ma_err, mb_vld, mb_err;
    int            ma_cnt, mb_cnt, mc_cnt;

    function automatic logic [XL-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Returns {err, data} straight from the select rules.
    function automatic logic [XL:0] ref_pick(input int mode, input int n,
                                             input logic [4*XL-1:0] flat, input int sel);
        int low;
        logic [XL-1:0] z;
        z = '0;
        if (mode == 0) begin
            if (sel < n) return {1'b0, flat[sel*XL +: XL]};
            return {1'b1, z};
        end
        if (sel == 0) return {1'b1, z};
        low = $clog2(sel & -sel);          // index of lowest set bit
        return {1'b0, flat[low*XL +: XL]};
    endfunction

    task automatic model_reg(input logic fl, input logic st, input logic v, input logic e,
                             input logic [XL-1:0] r, inout logic [XL-1:0] o,
                             inout logic ov, inout logic oe, inout int cnt);
        if (fl) begin
            ov = 1'b0;
            oe = 1'b0;
        end else if (!st) begin
            ov = v;
            if (v) begin
                o  = r;
                oe = e;
            end else begin
                oe = 1'b0;
            end
            if (v && e && cnt < 255) cnt++;
        end
    endtask

    // Advance the model for the current inputs, then cross one rising edge.
    task automatic tick();
        logic [XL:0] pa, pb, pc;
        pa = ref_pick(0, 3, {64'h0, a_in}, int'(a_sel));
        pb = ref_pick(1, 4, b_in, int'(b_sel));
        pc = ref_pick(0, 3, {64'h0, c_in}, int'(c_sel));
        model_reg(a_flush, a_stall, a_valid, pa[XL], pa[XL-1:0], ma_out, ma_vld, ma_err, ma_cnt);
        model_reg(b_flush, b_stall, b_valid, pb[XL], pb[XL-1:0], mb_out, mb_vld, mb_err, mb_cnt);
        if (c_valid && !c_flush && pc[XL] && mc_cnt < 255) mc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        ma_out = '0; ma_vld = 0; ma_err = 0; ma_cnt = 0;
        mb_out = '0; mb_vld = 0; mb_err = 0; mb_cnt = 0;
        mc_cnt = 0;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_stall = 0; a_flush = 0; a_sel = 0; a_in = '0;
        b_valid = 0; b_stall = 0; b_flush = 0; b_sel = 0; b_in = '0;
        c_valid = 0; c_stall = 0; c_flush = 0; c_sel = 0; c_in = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_clear();
        #3;
        tests++;
        if ({a_out, a_vld, a_err, a_cnt, b_out, b_vld, b_err, b_cnt, c_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_initial: a=%h/%b/%b/%0d b=%h/%b/%b/%0d c_cnt=%0d, need all 0",
                     a_out, a_vld, a_err, a_cnt, b_out, b_vld, b_err, b_cnt, c_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        // traffic including an illegal select so the counter is non-zero
        a_valid = 1; a_in = {rnd64(), rnd64(), rnd64()}; a_sel = 2'd1;
        tick();
        a_sel = 2'd3;
        tick();
        a_sel = 2'd0;
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        tests++;
        if ({a_out, a_vld, a_err, a_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_async: out=%h vld=%b err=%b cnt=%0d, need all 0", a_out, a_vld, a_err, a_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        a_in = '0;
        a_in[2*XL +: XL] = 64'hDEAD;
        a_sel = 2'd2; a_valid = 1;
        tick();
        tests++;
        if ({a_out, a_vld, a_err, a_cnt} !== {64'hDEAD, 1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset_first_op: out=%h vld=%b err=%b cnt=%0d, need dead/1/0/0", a_out, a_vld, a_err, a_cnt);
        end
    endtask

    task automatic test_illegal_bin();
        a_sel = 2'd3; a_valid = 1; a_in = {rnd64(), rnd64(), rnd64()};
        tick();
        tests++;
        if ({a_out, a_vld, a_err, a_cnt} !== {64'h0, 1'b1, 1'b1, 8'd1}) begin
            fails++;
            $display("FAIL illegal_sel: out=%h vld=%b err=%b cnt=%0d, need 0/1/1/1", a_out, a_vld, a_err, a_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            a_in = {rnd64(), rnd64(), rnd64()};
            tick();
            tests++;
            if ({a_out, a_vld, a_err, a_cnt} !== {ma_out, ma_vld, ma_err, 8'(ma_cnt)}) begin
                fails++;
                $display("FAIL illegal_loop[%0d]: got %h/%b/%b/%0d need %h/%b/%b/%0d", i,
                         a_out, a_vld, a_err, a_cnt, ma_out, ma_vld, ma_err, ma_cnt);
            end
        end
        tests++;
        if (a_cnt !== 8'd255) begin
            fails++;
            $display("FAIL err_cnt_saturate: got %0d need 255", a_cnt);
        end
    endtask

    task automatic test_onehot();
        logic [3:0] sels [3];
        logic [XL:0] need [3];
        sels[0] = 4'b0110; need[0] = {1'b0, 64'h11};
        sels[1] = 4'b1000; need[1] = {1'b0, 64'h13};
        sels[2] = 4'b0000; need[2] = {1'b1, 64'h0};
        b_in = {64'h13, 64'h12, 64'h11, 64'h10};
        b_valid = 1;
        for (int i = 0; i < 3; i++) begin
            b_sel = sels[i];
            tick();
            tests++;
            if ({b_err, b_out} !== need[i] || b_vld !== 1'b1) begin
                fails++;
                $display("FAIL onehot_sel_%b: out=%h err=%b vld=%b, need out=%h err=%b vld=1",
                         sels[i], b_out, b_err, b_vld, need[i][XL-1:0], need[i][XL]);
            end
        end
        for (int i = 0; i < 200; i++) begin
            b_in = {rnd64(), rnd64(), rnd64(), rnd64()};
            b_sel = 4'($urandom());
            b_valid = ($urandom_range(0, 3) != 0);
            b_stall = ($urandom_range(0, 3) == 0);
            b_flush = ($urandom_range(0, 7) == 0);
            tick();
            tests++;
            if ({b_out, b_vld, b_err, b_cnt} !== {mb_out, mb_vld, mb_err, 8'(mb_cnt)}) begin
                fails++;
                $display("FAIL onehot_rand[%0d]: got %h/%b/%b/%0d need %h/%b/%b/%0d", i,
                         b_out, b_vld, b_err, b_cnt, mb_out, mb_vld, mb_err, mb_cnt);
            end
        end
        b_valid = 0; b_stall = 0; b_flush = 0;
    endtask

    task automatic test_stall_flush();
        logic [7:0] cnt0;
        do_reset();
        a_in = '0; a_in[0 +: XL] = 64'hA5; a_sel = 2'd0; a_valid = 1; a_stall = 0; a_flush = 0;
        tick();
        tests++;
        if (a_out !== 64'hA5 || a_vld !== 1'b1) begin
            fails++;
            $display("FAIL stall_load: out=%h vld=%b, need a5/1", a_out, a_vld);
        end
        cnt0 = a_cnt;
        a_stall = 1;
        a_in[0 +: XL] = 64'h5A;
        for (int i = 0; i < 3; i++) begin
            a_sel = (i == 1) ? 2'd3 : 2'd0;   // illegal select while stalled must not count
            tick();
            tests++;
            if (a_out !== 64'hA5 || a_vld !== 1'b1 || a_err !== 1'b0 || a_cnt !== cnt0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: out=%h vld=%b err=%b cnt=%0d, need a5/1/0/%0d",
                         i, a_out, a_vld, a_err, a_cnt, cnt0);
            end
        end
        a_sel = 2'd0;
        a_flush = 1;
        tick();
        tests++;
        if (a_out !== 64'hA5 || a_vld !== 1'b0 || a_err !== 1'b0) begin
            fails++;
            $display("FAIL flush_with_stall: out=%h vld=%b err=%b, need a5/0/0", a_out, a_vld, a_err);
        end
        a_flush = 0; a_stall = 0;
        a_in[0 +: XL] = 64'h77;
        tick();
        tests++;
        if (a_out !== 64'h77 || a_vld !== 1'b1) begin
            fails++;
            $display("FAIL after_flush: out=%h vld=%b, need 77/1", a_out, a_vld);
        end
    endtask

    task automatic test_random_reg();
        for (int i = 0; i < 400; i++) begin
            a_in = {rnd64(), rnd64(), rnd64()};
            a_sel = 2'($urandom());
            a_valid = ($urandom_range(0, 3) != 0);
            a_stall = ($urandom_range(0, 3) == 0);
            a_flush = ($urandom_range(0, 7) == 0);
            tick();
            tests++;
            if ({a_out, a_vld, a_err, a_cnt} !== {ma_out, ma_vld, ma_err, 8'(ma_cnt)}) begin
                fails++;
                $display("FAIL bin_rand[%0d]: got %h/%b/%b/%0d need %h/%b/%b/%0d", i,
                         a_out, a_vld, a_err, a_cnt, ma_out, ma_vld, ma_err, ma_cnt);
            end
        end
        a_valid = 0; a_stall = 0; a_flush = 0;
    endtask

    task automatic test_comb();
        logic [XL:0] p;
        logic [7:0] cnt0;
        c_in = '0; c_in[1*XL +: XL] = 64'h1234; c_sel = 2'd1; c_valid = 1; c_flush = 0; c_stall = 0;
        #1;
        tests++;
        if (c_out !== 64'h1234 || c_vld !== 1'b1 || c_err !== 1'b0) begin
            fails++;
            $display("FAIL comb_pass: out=%h vld=%b err=%b, need 1234/1/0", c_out, c_vld, c_err);
        end
        cnt0 = c_cnt;
        c_flush = 1; c_sel = 2'd3;
        #1;
        tests++;
        if (c_vld !== 1'b0 || c_err !== 1'b0) begin
            fails++;
            $display("FAIL comb_flush: vld=%b err=%b, need 0/0", c_vld, c_err);
        end
        tick();
        tests++;
        if (c_cnt !== cnt0) begin
            fails++;
            $display("FAIL comb_flush_nocount: cnt=%0d need %0d", c_cnt, cnt0);
        end
        c_flush = 0; c_stall = 1;   // stall does not block acceptance here
        #1;
        tests++;
        if (c_out !== 64'h0 || c_vld !== 1'b1 || c_err !== 1'b1) begin
            fails++;
            $display("FAIL comb_illegal: out=%h vld=%b err=%b, need 0/1/1", c_out, c_vld, c_err);
        end
        tick();
        tests++;
        if (c_cnt !== cnt0 + 8'd1) begin
            fails++;
            $display("FAIL comb_count: cnt=%0d need %0d", c_cnt, cnt0 + 8'd1);
        end
        for (int i = 0; i < 200; i++) begin
            c_in = {rnd64(), rnd64(), rnd64()};
            c_sel = 2'($urandom());
            c_valid = ($urandom_range(0, 3) != 0);
            c_stall = ($urandom_range(0, 1) == 0);
            c_flush = ($urandom_range(0, 5) == 0);
            #1;
            p = ref_pick(0, 3, {64'h0, c_in}, int'(c_sel));
            tests++;
            if ({c_out, c_vld, c_err} !== {p[XL-1:0], c_valid & ~c_flush, p[XL] & c_valid & ~c_flush}) begin
                fails++;
                $display("FAIL comb_rand[%0d]: got %h/%b/%b need %h/%b/%b", i, c_out, c_vld, c_err,
                         p[XL-1:0], c_valid & ~c_flush, p[XL] & c_valid & ~c_flush);
            end
            tick();
            tests++;
            if (c_cnt !== 8'(mc_cnt)) begin
                fails++;
                $display("FAIL comb_rand_cnt[%0d]: got %0d need %0d", i, c_cnt, mc_cnt);
            end
        end
        c_valid = 0; c_stall = 0; c_flush = 0;
    endtask

    initial begin
        test_reset();
        test_illegal_bin();
        test_onehot();
        test_stall_flush();
        test_random_reg();
        test_comb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/riscv_core_muxnx1_pipe.md
Name: riscv_core_muxnx1_pipe

Overview:
Parametrised N-input operand/forwarding selector with an optional pipeline register stage. It replaces fixed 3:1 combinational selects in the execute/forwarding path. It adds:
- binary or one-hot-priority select modes
- valid/stall/flush pipeline control
- out-of-range select detection, with a saturating error counter for debug visibility.

Parameters:
XLEN, 64, data width of each input and of the output
NUM_IN, 4, number of data inputs (2..16)
SEL_MODE, 0, 0 = binary select; 1 = one-hot select with lowest-index priority
SEL_W, (SEL_MODE ? NUM_IN : $clog2(NUM_IN)), select width (derived, not overridden)
REG_OUT, 1, 1 = registered output stage; 0 = combinational pass-through
ERR_CNT_W, 8, width of the saturating error counter

Ports:
i_clk  input  1  core clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_mux_in  input  NUM_IN*XLEN  flattened data inputs; input k occupies bits [k*XLEN +: XLEN]
i_mux_sel  input  SEL_W  select (binary or one-hot per SEL_MODE)
i_mux_valid  input  1  input data/select valid this cycle
i_mux_stall  input  1  hold the output register (pipeline stall)
i_mux_flush  input  1  kill the registered entry
o_mux_out  output  XLEN  selected data
o_mux_valid  output  1  o_mux_out valid
o_mux_sel_err  output  1  select was illegal for the presented/held entry
o_mux_err_cnt  output  ERR_CNT_W  count of accepted illegal selects, saturating

Behaviour:
- Select decode (combinational):
  - SEL_MODE=0: legal if sel < NUM_IN; result = input[sel].
  - SEL_MODE=1: legal if sel != 0; result = input at the lowest set bit. Multiple set bits are legal; lowest index wins.
  - Illegal select: result = all zeros, err = 1.
- REG_OUT=1, priority per rising edge:
  1. i_mux_flush=1: o_mux_valid <= 0 and o_mux_sel_err <= 0. o_mux_out holds. Flush beats stall and beats new input.
  2. Else i_mux_stall=1: all outputs hold. Input is ignored and not counted.
  3. Else: o_mux_valid <= i_mux_valid. If i_mux_valid=1, o_mux_out <= result and o_mux_sel_err <= err. If i_mux_valid=0, o_mux_out holds and o_mux_sel_err <= 0.
- Latency with REG_OUT=1: 1 cycle from accepted input to output.
- REG_OUT=0:
  - Outputs are combinational: o_mux_out = result, o_mux_valid = i_mux_valid & ~i_mux_flush, o_mux_sel_err = err & o_mux_valid.
  - i_mux_stall has no effect on data.
- Error counter (both REG_OUT modes):
  - Increments by 1 on each clock edge where an entry is accepted with err=1.
  - Accepted means i_mux_valid & ~i_mux_flush & ~i_mux_stall, with stall considered only when REG_OUT=1.
  - Saturates at 2^ERR_CNT_W-1 and never wraps.
  - Cleared only by reset.
- Reset (asynchronous, active-high, takes effect immediately with i_rst=1): o_mux_out=0, o_mux_valid=0, o_mux_sel_err=0, o_mux_err_cnt=0.
- Reset mid-stall or mid-flush: outputs go to reset values. The first edge after reset deassertion operates normally.
- The select value of a stalled cycle is never sampled; a change of select during stall does not affect held output.
- Elaboration rules:
  - NUM_IN < 2 or NUM_IN > 16 is an error.
  - With SEL_MODE=0 and NUM_IN a power of two, no select value is illegal, so err is constant 0.

Test Plan:
1. Reset (REG_OUT=1, NUM_IN=3, SEL_MODE=0): assert i_rst mid-cycle with valid traffic -> all outputs 0 immediately. Release, then present in2=0xDEAD, sel=2, valid=1 -> next cycle o_mux_out=0xDEAD, o_mux_valid=1, o_mux_sel_err=0.
2. Illegal binary select (NUM_IN=3): sel=3, valid=1 -> next cycle out=0, sel_err=1, err_cnt=1. Repeat 300 accepted illegal selects with ERR_CNT_W=8 -> err_cnt sticks at 255.
3. One-hot priority (SEL_MODE=1, NUM_IN=4, in0..in3=0x10,0x11,0x12,0x13):
   - sel=4'b0110 -> out=0x11.
   - sel=4'b1000 -> out=0x13.
   - sel=0 -> out=0, sel_err=1.
4. Stall and flush:
   - Load 0xA5 -> out=0xA5.
   - Stall 3 cycles while inputs change to 0x5A -> out stays 0xA5, valid stays 1, err_cnt unchanged.
   - Assert flush+stall together -> valid=0, out holds 0xA5.
   - Next edge with valid=1 and data 0x77 -> out=0x77.
5. REG_OUT=0: in1=0x1234, sel=1, valid=1 -> out=0x1234 in the same cycle. Flush=1 -> o_mux_valid=0 in the same cycle, and an illegal select presented in that cycle is not counted.
